core_wb_adapter: RTL and testbench

CORE_WB_ADAPTER -- requirements
Module: core_wb_adapter

---
 rtl/core_bus_pkg.sv | 16 +
 rtl/bus_timeout_counter.sv | 43 ++++
 rtl/core_wb_adapter.sv | 135 +++++++++++++
 tb/tb_core_wb_adapter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_pkg.sv
// Shared FSM encoding and timeout-counter sizing for the core-to-Wishbone adapter.
package core_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_STROBE = 4'b0010,
    ST_WAIT   = 4'b0100,
    ST_RESP   = 4'b1000
  } bus_state_e;

  // A disabled timeout (0 cycles) still needs a 1-bit counter to stay legal.
  function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
    return (cycles == 32'd0) ? 32'd1 : $clog2(cycles + 32'd1);
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles a bus access has been in flight; flags when LIMIT is reached.
module bus_timeout_counter
  import core_bus_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned W = tmo_cnt_width(LIMIT);
  localparam logic [W-1:0] LIMIT_C = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired_o = (LIMIT != 32'd0) && (cnt_q == LIMIT_C);

  // Next count: clear on a new access, otherwise hold once the limit is hit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/core_wb_adapter.sv
// Single-outstanding core request to Wishbone master adapter (classic or pipelined),
// with optional registered response and a strobe-to-ack timeout.
module core_wb_adapter
  import core_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned PIPELINED      = 0,
  parameter int unsigned REG_RESPONSE   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] ben_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    gnt_o,
  output logic                    err_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    cyc_o,
  output logic                    stb_o,
  output logic                    we_o,
  output logic [DATA_WIDTH/8-1:0] sel_o,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic                    ack_i,
  input  logic                    err_i,
  input  logic                    stall_i
);

  localparam int unsigned BW = DATA_WIDTH / 8;

  bus_state_e            state_q;
  logic                  we_q;
  logic [BW-1:0]         sel_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  resp_err_q;
  logic [DATA_WIDTH-1:0] resp_data_q;

  logic on_bus_s;
  logic accept_s;
  logic direct_s;
  logic expired_s;

  assign on_bus_s = (state_q == ST_STROBE) || (state_q == ST_WAIT);
  assign accept_s = (state_q == ST_IDLE) && req_i;
  assign direct_s = (REG_RESPONSE == 32'd0) && on_bus_s && (ack_i || err_i);

  bus_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clear_i   (accept_s),
    .enable_i  (on_bus_s),
    .expired_o (expired_s)
  );

  // Transaction FSM; the bus side only ever sees the copy latched at acceptance.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            sel_q   <= ben_i;
            adr_q   <= addr_i;
            dat_q   <= wdata_i;
            state_q <= ST_STROBE;
          end
        end
        ST_STROBE, ST_WAIT: begin
          if (ack_i || err_i) begin
            // err_i wins over a simultaneous ack_i and suppresses the data.
            resp_err_q  <= err_i;
            resp_data_q <= (err_i || we_q) ? '0 : dat_i;
            state_q     <= (REG_RESPONSE != 32'd0) ? ST_RESP : ST_IDLE;
          end else if (expired_s) begin
            resp_err_q  <= 1'b1;
            resp_data_q <= '0;
            state_q     <= ST_RESP;
          end else if ((PIPELINED != 32'd0) && (state_q == ST_STROBE) && !stall_i) begin
            state_q <= ST_WAIT;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cyc_o = on_bus_s;
  assign stb_o = (state_q == ST_STROBE);
  assign we_o  = we_q;
  assign sel_o = sel_q;
  assign adr_o = adr_q;
  assign dat_o = dat_q;

  // Completion: same-cycle pass-through, or the captured response from RESP.
  always_comb begin
    gnt_o   = 1'b0;
    err_o   = 1'b0;
    rdata_o = '0;
    if (direct_s) begin
      gnt_o   = 1'b1;
      err_o   = err_i;
      rdata_o = (err_i || we_q) ? '0 : dat_i;
    end else if (state_q == ST_RESP) begin
      gnt_o   = 1'b1;
      err_o   = resp_err_q;
      rdata_o = resp_data_q;
    end else begin
      gnt_o   = 1'b0;
      err_o   = 1'b0;
      rdata_o = '0;
    end
  end

endmodule

// File: tb/tb_core_wb_adapter.sv
// Scoreboard bench: four adapter instances (classic/pipelined x direct/registered response).
module tb_core_wb_adapter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int BW  = DW / 8;
  localparam int TMO = 4;

  typedef struct {
    int            cyc;
    logic          err;
    logic [DW-1:0] rdata;
    logic          cyc_hi;
  } gnt_rec_t;

  typedef struct {
    logic          we;
    logic [BW-1:0] sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    int            stb_len;
    int            cyc_len;
  } bus_rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  initial forever begin
    @(posedge clk);
    cycle = cycle + 1;
  end

  task automatic chk(input int ln, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lane%0d %s actual=%0h required=%0h", ln, name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int P = g % 2;
    localparam int R = g / 2;

    logic          rstn, req, we, gnt, gerr, cyc, stb, bwe, ack, err, stall;
    logic [BW-1:0] ben, sel;
    logic [AW-1:0] addr, adr;
    logic [DW-1:0] wdata, rdat, dato, dati;
    bit            lane_done = 1'b0;
    gnt_rec_t      gq[$];
    bus_rec_t      bq[$];

    core_wb_adapter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIPELINED(P),
      .REG_RESPONSE(R), .TIMEOUT_CYCLES(TMO)
    ) dut (
      .clk_i(clk), .rstn_i(rstn), .req_i(req), .we_i(we), .ben_i(ben),
      .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .err_o(gerr), .rdata_o(rdat),
      .cyc_o(cyc), .stb_o(stb), .we_o(bwe), .sel_o(sel), .adr_o(adr), .dat_o(dato),
      .dat_i(dati), .ack_i(ack), .err_i(err), .stall_i(stall)
    );

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    // Bus-side and payload noise; the DUT must ignore it outside the relevant states.
    task automatic noise();
      ack   = 1'($urandom);
      err   = 1'($urandom);
      stall = 1'($urandom);
      dati  = $urandom;
      we    = 1'($urandom);
      ben   = BW'($urandom);
      addr  = $urandom;
      wdata = $urandom;
    endtask

    task automatic run_txn(input logic twe, input logic [BW-1:0] tben, input logic [AW-1:0] taddr,
                           input logic [DW-1:0] twdata, input logic [DW-1:0] trdat,
                           input int ts, input int tk, input int tkind, input int textra);
      int s, endi, gidx;
      bit tmo, terr;
      gnt_rec_t gr;
      bus_rec_t br;
      s    = (P != 0) ? ts : 0;
      tmo  = (tk > TMO);
      endi = tmo ? TMO : tk;
      gidx = (tmo || R != 0) ? endi + 1 : endi;
      terr = tmo || (tkind != 0);
      step();
      noise();
      req = 1'b1; we = twe; ben = tben; addr = taddr; wdata = twdata;
      gr.cyc     = cycle + 1 + gidx;
      gr.err     = terr;
      gr.rdata   = (terr || twe) ? '0 : trdat;
      gr.cyc_hi  = !(tmo || R != 0);
      br.we      = twe;
      br.sel     = tben;
      br.adr     = taddr;
      br.dat     = twdata;
      br.stb_len = ((P != 0) ? ((s < endi) ? s : endi) : endi) + 1;
      br.cyc_len = endi + 1;
      gq.push_back(gr);
      bq.push_back(br);
      for (int i = 0; i <= gidx + textra; i++) begin
        step();
        noise();
        req = (i <= gidx) ? 1'($urandom) : 1'b0;
        if (i <= endi) begin
          if (P != 0) stall = (i < s) ? 1'b1 : ((i == s) ? 1'b0 : 1'($urandom));
          ack = 1'b0;
          err = 1'b0;
          if (i == tk && !tmo) begin
            ack  = (tkind != 1);
            err  = (tkind != 0);
            dati = trdat;
          end
        end
      end
    endtask

    // Reset asserted mid-access at index j: cycle must vanish at once, no grant ever.
    task automatic abort_txn(input int ts, input int j);
      int s;
      bus_rec_t br;
      s = (P != 0) ? ts : 0;
      step();
      noise();
      req = 1'b1;
      br.we = we; br.sel = ben; br.adr = addr; br.dat = wdata;
      br.stb_len = (P != 0) ? (((s + 1) < j) ? (s + 1) : j) : j;
      br.cyc_len = j;
      bq.push_back(br);
      for (int i = 0; i < j; i++) begin
        step();
        noise();
        req = 1'b0;
        ack = 1'b0;
        err = 1'b0;
        if (P != 0) stall = (i < s) ? 1'b1 : ((i == s) ? 1'b0 : 1'($urandom));
      end
      step();
      rstn = 1'b0;
      #1;
      chk(g, "abort_cyc", 64'(cyc), 64'd0);
      chk(g, "abort_stb", 64'(stb), 64'd0);
      chk(g, "abort_gnt", 64'(gnt), 64'd0);
      step();
      noise();
      req = 1'b1;
      step();
      req = 1'b0;
      rstn = 1'b1;
      chk(g, "abort_adr", 64'(adr), 64'd0);
      chk(g, "abort_sel_we", 64'({sel, bwe}), 64'd0);
    endtask

    // Monitor: pops expected grants and bus address phases as the DUT presents them.
    initial begin
      bit prev, have;
      int ncyc, nstb;
      bus_rec_t cur;
      gnt_rec_t gr;
      prev = 1'b0; have = 1'b0; ncyc = 0; nstb = 0;
      forever begin
        @(negedge clk);
        if (gnt === 1'b1) begin
          chk(g, "gnt_expected", 64'(gq.size() != 0), 64'd1);
          if (gq.size() != 0) begin
            gr = gq.pop_front();
            chk(g, "gnt_cycle", 64'(cycle), 64'(gr.cyc));
            chk(g, "err_o", 64'(gerr), 64'(gr.err));
            chk(g, "rdata_o", 64'(rdat), 64'(gr.rdata));
            chk(g, "cyc_at_gnt", 64'(cyc), 64'(gr.cyc_hi));
          end
        end
        if (cyc === 1'b1 && !prev) begin
          chk(g, "cyc_expected", 64'(bq.size() != 0), 64'd1);
          have = (bq.size() != 0);
          if (have) begin
            cur = bq.pop_front();
            chk(g, "we_o", 64'(bwe), 64'(cur.we));
            chk(g, "sel_o", 64'(sel), 64'(cur.sel));
            chk(g, "adr_o", 64'(adr), 64'(cur.adr));
            chk(g, "dat_o", 64'(dato), 64'(cur.dat));
          end
          ncyc = 1;
          nstb = (stb === 1'b1) ? 1 : 0;
        end else if (cyc === 1'b1) begin
          ncyc++;
          if (stb === 1'b1) nstb++;
        end else if (prev && have) begin
          chk(g, "stb_len", 64'(nstb), 64'(cur.stb_len));
          chk(g, "cyc_len", 64'(ncyc), 64'(cur.cyc_len));
        end
        prev = (cyc === 1'b1);
      end
    end

    // Stimulus: reset, directed corner cases, random traffic, reset abort, recovery.
    initial begin
      rstn = 1'b0;
      req  = 1'b0;
      noise();
      repeat (3) step();
      chk(g, "rst_bus_ctl", 64'({cyc, stb, bwe}), 64'd0);
      chk(g, "rst_gnt_err", 64'({gnt, gerr}), 64'd0);
      chk(g, "rst_sel_adr", 64'({sel, adr}), 64'd0);
      chk(g, "rst_dat_rdata", 64'({dato, rdat}), 64'd0);
      rstn = 1'b1;
      run_txn(1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 3, 0, 1);
      run_txn(1'b1, 4'h3, 32'h0000_0200, 32'h0000_A5A5, 32'h1111_1111, 2, 3, 0, 0);
      run_txn(1'b0, 4'hF, 32'h0000_0300, 32'h0, 32'h1234_5678, 0, 1, 0, 0);
      run_txn(1'b0, 4'hF, 32'h0000_0400, 32'h0, 32'h5555_AAAA, 1, 9, 0, 2);
      run_txn(1'b0, 4'hF, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, 0, 2, 2, 1);
      run_txn(1'b1, 4'hC, 32'h0000_0600, 32'hBEEF_0001, 32'h0, 0, 0, 1, 0);
      run_txn(1'b0, 4'hF, 32'h0000_0700, 32'h0, 32'h0BAD_CAFE, 0, TMO, 0, 0);
      for (int n = 0; n < 40; n++) begin
        int s, k;
        s = $urandom_range(0, 3);
        k = s + $urandom_range(0, 4);
        run_txn(1'($urandom), BW'($urandom), $urandom, $urandom, $urandom,
                s, k, $urandom_range(0, 2), $urandom_range(0, 2));
      end
      abort_txn(0, 3);
      run_txn(1'b0, 4'hF, 32'h0000_0800, 32'h0, 32'h7777_8888, 0, 2, 0, 1);
      repeat (4) step();
      chk(g, "gnt_queue_drained", 64'(gq.size()), 64'd0);
      chk(g, "bus_queue_drained", 64'(bq.size()), 64'd0);
      lane_done = 1'b1;
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (!(lane[0].lane_done && lane[1].lane_done && lane[2].lane_done && lane[3].lane_done)
           && waited < 20000) begin
      @(posedge clk);
      waited++;
    end
    checks++;
    if (waited >= 20000) begin
      errors++;
      $display("FAIL run_complete actual=timeout required=all_lanes_done");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
